// File: rtl/injection_scheduler.sv
// Run-level injection scheduler for the 3x3 NoC bench fabric: round-robin send strobes, in-flight cap, inter-send gap.
// Latency: send is registered; a grant decided at an edge appears as a 1-cycle strobe in the following cycle.
// Backpressure: busy sources are skipped; sends stall on the in-flight cap or the gap. Optional macro: INJ_CYCLE_COUNT_EN.
module injection_scheduler #(
   parameter int NUM_NODES    = 9,
   parameter int CNT_BITS     = 16,
   parameter int GAP_BITS     = 8,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [CNT_BITS-1:0]  i_num_packets,
   input  logic [GAP_BITS-1:0]  i_gap,
   input  logic [NUM_NODES-1:0] i_source_busy,
   input  logic [NUM_NODES-1:0] i_delivered,
   output logic [NUM_NODES-1:0] o_send,
   output logic [CNT_BITS-1:0]  o_injected,
   output logic [CNT_BITS-1:0]  o_inflight,
   output logic [1:0]           o_state,
   output logic                 o_done,
   output logic                 o_error,
   output logic [CNT_BITS-1:0]  o_run_cycles
);

   localparam int PTR_BITS = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
   localparam int POP_BITS = $clog2(NUM_NODES + 1);
   localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_INFLIGHT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_INJECT = 2'd1,
      S_DRAIN  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                r_state;
   logic                  r_done;
   logic                  r_error;
   logic [NUM_NODES-1:0]  r_send;
   logic [CNT_BITS-1:0]   r_injected;
   logic [CNT_BITS-1:0]   r_inflight;
   logic [CNT_BITS-1:0]   r_num_pkts;
   logic [GAP_BITS-1:0]   r_gap;
   logic [GAP_BITS-1:0]   r_gap_cnt;
   logic [PTR_BITS-1:0]   r_ptr;
   logic [CNT_BITS-1:0]   r_run_cycles;

   logic [POP_BITS-1:0]   w_dlv_cnt;
   logic [CNT_BITS-1:0]   w_dlv_ext;
   logic                  w_underflow;
   logic [CNT_BITS-1:0]   w_inflight_net;
   logic                  w_start_run;
   logic                  w_slot_open;
   logic                  w_found;
   logic [PTR_BITS-1:0]   w_grant_idx;
   logic [PTR_BITS-1:0]   w_scan;
   logic                  w_grant;
   logic [NUM_NODES-1:0]  w_send_vec;

   // Count every delivered pulse this cycle; several sinks may complete at once.
   always_comb begin
      w_dlv_cnt = '0;
      for (int k = 0; k < NUM_NODES; k++) begin
         w_dlv_cnt = w_dlv_cnt + POP_BITS'(i_delivered[k]);
      end
   end

   assign w_dlv_ext = CNT_BITS'(w_dlv_cnt);

   // More deliveries than tracked packets: clamp to zero and flag it (a grant still adds on top).
   assign w_underflow    = (w_dlv_ext > r_inflight);
   assign w_inflight_net = w_underflow ? '0 : (r_inflight - w_dlv_ext);

   assign w_start_run = (r_state == S_IDLE) && i_start && !i_abort;

   // Round-robin scan: first idle source after the last granted one, wrapping around.
   always_comb begin
      w_found     = 1'b0;
      w_grant_idx = '0;
      w_scan      = '0;
      for (int i = 1; i <= NUM_NODES; i++) begin
         w_scan = PTR_BITS'((int'(r_ptr) + i) % NUM_NODES);
         if (!w_found && !i_source_busy[w_scan]) begin
            w_found     = 1'b1;
            w_grant_idx = w_scan;
         end
      end
   end

   // Send opportunity for the coming cycle. On the start edge the counters are about
   // to be cleared, so only the fresh packet count matters (the cap is at least 1).
   always_comb begin
      w_slot_open = 1'b0;
      if (w_start_run) begin
         w_slot_open = (i_num_packets != '0);
      end else begin
         w_slot_open = (r_state == S_INJECT) &&
                       (r_gap_cnt == '0) &&
                       (r_injected < r_num_pkts) &&
                       (w_inflight_net < MAX_CNT);
      end
   end

   assign w_grant    = w_slot_open && w_found && !i_abort;
   assign w_send_vec = NUM_NODES'(1) << w_grant_idx;

   // Run sequencer with registered send strobe and packet accounting.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_send     <= '0;
         r_injected <= '0;
         r_inflight <= '0;
         r_num_pkts <= '0;
         r_gap      <= '0;
         r_gap_cnt  <= '0;
         r_ptr      <= PTR_BITS'(NUM_NODES - 1);
      end else begin
         r_send <= '0;
         if (i_abort) begin
            // Counters freeze; only the sequencer returns home.
            r_state <= S_IDLE;
            r_done  <= 1'b0;
         end else begin
            r_inflight <= w_inflight_net + CNT_BITS'(w_grant);
            r_error    <= r_error | w_underflow;
            if (w_grant) begin
               r_send     <= w_send_vec;
               r_ptr      <= w_grant_idx;
               r_injected <= r_injected + 1'b1;
               r_gap_cnt  <= r_gap;
            end else if (r_gap_cnt != '0) begin
               r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_num_pkts <= i_num_packets;
                     r_gap      <= i_gap;
                     r_injected <= CNT_BITS'(w_grant);
                     r_inflight <= CNT_BITS'(w_grant);
                     r_error    <= 1'b0;
                     r_gap_cnt  <= w_grant ? i_gap : '0;
                     r_state    <= (i_num_packets == '0) ? S_DRAIN : S_INJECT;
                  end
               end
               S_INJECT: begin
                  if (r_injected >= r_num_pkts) begin
                     r_state <= S_DRAIN;
                  end
               end
               S_DRAIN: begin
                  if (w_inflight_net == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
               S_DONE: begin
                  if (!i_start) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b0;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef INJ_CYCLE_COUNT_EN
   // Saturating run-length counter over INJECT and DRAIN; frozen in DONE/IDLE and on abort.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_run_cycles <= '0;
      end else if (!i_abort) begin
         if (w_start_run) begin
            r_run_cycles <= '0;
         end else if (((r_state == S_INJECT) || (r_state == S_DRAIN)) && (r_run_cycles != '1)) begin
            r_run_cycles <= r_run_cycles + 1'b1;
         end
      end
   end
`else
   assign r_run_cycles = '0;
`endif

   assign o_send       = r_send;
   assign o_injected   = r_injected;
   assign o_inflight   = r_inflight;
   assign o_state      = r_state;
   assign o_done       = r_done;
   assign o_error      = r_error;
   assign o_run_cycles = r_run_cycles;

endmodule
